// File: rtl/ws2812_pixel_tx.sv
// ws2812_pixel_tx: WS2812 pixel serializer with per-bit pulse timing, inter-pixel gap timeout and frame latch; `WS2812_GRB_ORDER_EN swaps the upper two bytes before shifting
module ws2812_pixel_tx #(
   parameter int T1H            = 40,
   parameter int T1L            = 20,
   parameter int T0H            = 20,
   parameter int T0L            = 40,
   parameter int T_RESET        = 2500,
   parameter int BITS_PER_PIXEL = 24,
   parameter int NUM_PIXELS     = 8
) (
   input  logic                      Clock_50,
   input  logic                      Reset,
   input  logic [BITS_PER_PIXEL-1:0] pixel_data,
   input  logic                      pixel_valid,
   output logic                      pixel_ready,
   output logic                      out,
   output logic                      busy,
   output logic                      frame_done,
   output logic                      underrun
);
   localparam int BPP     = BITS_PER_PIXEL;
   localparam int T1      = T1H + T1L;
   localparam int T0      = T0H + T0L;
   localparam int MAX_BIT = (T1 > T0) ? T1 : T0;
   localparam int MAX_T   = (T_RESET > MAX_BIT) ? T_RESET : MAX_BIT;
   localparam int CW      = $clog2(MAX_T + 1);
   localparam int IW      = $clog2(NUM_PIXELS + 1);
   localparam int BW      = $clog2(BPP);

   localparam logic [CW-1:0] C1H   = CW'(T1H - 1);
   localparam logic [CW-1:0] C1L   = CW'(T1L - 1);
   localparam logic [CW-1:0] C0H   = CW'(T0H - 1);
   localparam logic [CW-1:0] C0L   = CW'(T0L - 1);
   localparam logic [CW-1:0] CRST  = CW'(T_RESET - 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_PIXELS - 1);
   localparam logic [BW-1:0] MSB_BIT  = BW'(BPP - 1);

   typedef enum logic [2:0] {IDLE, HIGH, LOW, GAP, LATCH} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [BPP-1:0]  sh_q, sh_d;
   logic [BW-1:0]   bit_q, bit_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic            flag_q, flag_d;
   logic            out_q, out_d;
   logic            done_q, done_d;
   logic            und_q, und_d;
   logic [BPP-1:0]  load_w;
   logic            last_low;
   logic            acc;

`ifdef WS2812_GRB_ORDER_EN
   assign load_w = {pixel_data[BPP-9:BPP-16], pixel_data[BPP-1:BPP-8], pixel_data[BPP-17:0]};
`else
   assign load_w = pixel_data;
`endif

   assign last_low    = (state_q == LOW) && (cnt_q == '0);
   assign pixel_ready = (state_q == IDLE) || (state_q == GAP) ||
                        (last_low && (bit_q == '0) && (idx_q != LAST_IDX));
   assign acc         = pixel_valid && pixel_ready;
   assign busy        = (state_q != IDLE);
   assign out         = out_q;
   assign frame_done  = done_q;
   assign underrun    = und_q;

   // state register; reset parks the line low in a full latch period
   always_ff @(posedge Clock_50) begin
      if (Reset) begin
         state_q <= LATCH;
         cnt_q   <= CRST;
         sh_q    <= '0;
         bit_q   <= '0;
         idx_q   <= '0;
         flag_q  <= 1'b0;
         out_q   <= 1'b0;
         done_q  <= 1'b0;
         und_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sh_q    <= sh_d;
         bit_q   <= bit_d;
         idx_q   <= idx_d;
         flag_q  <= flag_d;
         out_q   <= out_d;
         done_q  <= done_d;
         und_q   <= und_d;
      end
   end

   // next state: acceptance restarts HIGH at the MSB, otherwise count down the current phase
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sh_d    = sh_q;
      bit_d   = bit_q;
      idx_d   = idx_q;
      flag_d  = flag_q;
      out_d   = out_q;
      done_d  = 1'b0;
      und_d   = 1'b0;
      if (acc) begin
         state_d = HIGH;
         out_d   = 1'b1;
         sh_d    = load_w;
         bit_d   = MSB_BIT;
         cnt_d   = load_w[BPP-1] ? C1H : C0H;
         idx_d   = (state_q == IDLE) ? '0 : idx_q + IW'(1);
      end else begin
         case (state_q)
            HIGH: begin
               if (cnt_q == '0) begin
                  out_d   = 1'b0;
                  state_d = LOW;
                  cnt_d   = sh_q[BPP-1] ? C1L : C0L;
               end else begin
                  cnt_d = cnt_q - CW'(1);
               end
            end
            LOW: begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - CW'(1);
               end else if (bit_q != '0) begin
                  sh_d    = sh_q << 1;
                  bit_d   = bit_q - BW'(1);
                  out_d   = 1'b1;
                  state_d = HIGH;
                  cnt_d   = sh_q[BPP-2] ? C1H : C0H;
               end else if (idx_q != LAST_IDX) begin
                  state_d = GAP;
                  cnt_d   = CRST;
               end else begin
                  state_d = LATCH;
                  cnt_d   = CRST;
                  flag_d  = 1'b1;
               end
            end
            GAP: begin
               if (cnt_q == '0) begin
                  und_d   = 1'b1;
                  idx_d   = '0;
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q - CW'(1);
               end
            end
            LATCH: begin
               if (cnt_q == '0) begin
                  done_d  = flag_q;
                  flag_d  = 1'b0;
                  idx_d   = '0;
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q - CW'(1);
               end
            end
            default: begin
               idx_d = '0;
               out_d = 1'b0;
            end
         endcase
      end
   end
endmodule
